// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg
// Shared types and helpers for the alarm clock blocks.
//   state_e      : key controller FSM states
//   TIMEOUT_S_DEF: default inactivity timeout in one_second ticks
//   BCD_W        : width of one BCD digit
//   hhmm_valid() : true when a {H1,H0,M1,M0} BCD value is a legal 24h time
//                  (also used by the time counter)
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        SHOW_TIME  = 2'd0,
        KEY_ENTRY  = 2'd1,
        SHOW_ALARM = 2'd2
    } state_e;

    localparam int TIMEOUT_S_DEF = 10;
    localparam int BCD_W         = 4;

    function automatic logic hhmm_valid(input logic [4*BCD_W-1:0] t);
        logic [BCD_W-1:0] h1, h0, m1, m0;
        logic digits_ok, hours_ok, mins_ok;
        h1 = t[15:12];
        h0 = t[11:8];
        m1 = t[7:4];
        m0 = t[3:0];
        digits_ok = (h1 <= 4'd9) && (h0 <= 4'd9) && (m1 <= 4'd9) && (m0 <= 4'd9);
        // 00..19 any units digit, 20..23 only units 0..3
        hours_ok  = (h1 < 4'd2) || ((h1 == 4'd2) && (h0 <= 4'd3));
        mins_ok   = (m1 <= 4'd5);
        return digits_ok && hours_ok && mins_ok;
    endfunction

endpackage

// File: rtl/alarm_key_shift_reg.sv
// alarm_key_shift_reg
// Four-digit BCD shift buffer holding the value being keyed in.
//   clock_i  : system clock
//   reset_i  : synchronous active-high reset, clears the buffer
//   clear_i  : synchronous clear
//   shift_i  : shift digit_i into the low digit, oldest digit drops off
//   digit_i  : BCD digit to shift in
//   value_o  : buffer contents {H1,H0,M1,M0}
// When clear_i and shift_i are both high the result is {0,0,0,digit_i}, so a
// digit arriving the cycle after a load starts a fresh entry.
module alarm_key_shift_reg
    import alarm_clock_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 shift_i,
    input  logic [BCD_W-1:0]     digit_i,
    output logic [4*BCD_W-1:0]   value_o
);

    logic [4*BCD_W-1:0] value_q, value_d, base;

    always_comb begin
        base    = clear_i ? '0 : value_q;
        value_d = base;
        if (shift_i) begin
            value_d = {base[3*BCD_W-1:0], digit_i};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/alarm_key_controller.sv
// alarm_key_controller
// Keypad entry controller: assembles BCD digits into HH:MM and issues
// one-cycle load strobes to the alarm register / time counter.
//   clock_i, reset_i   : clock, synchronous active-high reset
//   one_second_i       : one-cycle time base tick
//   key_i, key_valid_i : keypad code and its strobe (0..9 are digits)
//   alarm_button_i     : level, synchronized
//   time_button_i      : level, synchronized
//   new_time_o         : entered value {H1,H0,M1,M0}
//   load_alarm_o       : strobe, alarm register captures new_time_o
//   load_time_o        : strobe, time counter captures new_time_o
//   show_alarm_o       : display selects stored alarm time
//   show_new_time_o    : display selects new_time_o
//   entry_error_o      : strobe, load rejected by range check
// Optional feature: define ALARM_KEY_RANGE_CHECK_EN to reject out-of-range
// HH:MM values on load; otherwise values load unchecked and entry_error_o
// stays 0.
module alarm_key_controller
    import alarm_clock_pkg::*;
#(
    parameter int TIMEOUT_S = TIMEOUT_S_DEF
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        one_second_i,
    input  logic [3:0]  key_i,
    input  logic        key_valid_i,
    input  logic        alarm_button_i,
    input  logic        time_button_i,
    output logic [15:0] new_time_o,
    output logic        load_alarm_o,
    output logic        load_time_o,
    output logic        show_alarm_o,
    output logic        show_new_time_o,
    output logic        entry_error_o
);

    localparam int CNT_W = $clog2(TIMEOUT_S + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_S - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             load_alarm_q, load_time_q, entry_error_q;
    logic             show_alarm_q, show_new_time_q;

    logic             digit_ok, digit_accept, buf_clear, range_ok, any_button;

    assign digit_ok   = key_valid_i && (key_i <= 4'd9);
    assign any_button = alarm_button_i || time_button_i;

    // Buttons beat digits: in SHOW_TIME only alarm_button matters, in
    // KEY_ENTRY either button discards a same-cycle digit.
    always_comb begin
        digit_accept = 1'b0;
        case (state_q)
            SHOW_TIME: digit_accept = digit_ok && !alarm_button_i;
            KEY_ENTRY: digit_accept = digit_ok && !any_button;
            default:   digit_accept = 1'b0;
        endcase
    end

    // The buffer is held clear throughout SHOW_TIME; since the load edge
    // leaves the FSM in SHOW_TIME, the value survives the strobe cycle and
    // clears at the following edge.
    assign buf_clear = (state_q == SHOW_TIME);

`ifdef ALARM_KEY_RANGE_CHECK_EN
    assign range_ok = hhmm_valid(new_time_o);
`else
    assign range_ok = 1'b1;
`endif

    alarm_key_shift_reg u_shift (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (buf_clear),
        .shift_i (digit_accept),
        .digit_i (key_i),
        .value_o (new_time_o)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= SHOW_TIME;
            cnt_q           <= '0;
            load_alarm_q    <= 1'b0;
            load_time_q     <= 1'b0;
            entry_error_q   <= 1'b0;
            show_alarm_q    <= 1'b0;
            show_new_time_q <= 1'b0;
        end else begin
            load_alarm_q  <= 1'b0;
            load_time_q   <= 1'b0;
            entry_error_q <= 1'b0;
            case (state_q)
                SHOW_TIME: begin
                    cnt_q <= '0;
                    if (alarm_button_i) begin
                        state_q      <= SHOW_ALARM;
                        show_alarm_q <= 1'b1;
                    end else if (digit_accept) begin
                        state_q         <= KEY_ENTRY;
                        show_new_time_q <= 1'b1;
                    end
                end
                KEY_ENTRY: begin
                    if (any_button) begin
                        state_q         <= SHOW_TIME;
                        show_new_time_q <= 1'b0;
                        cnt_q           <= '0;
                        if (range_ok) begin
                            // time_button wins when both are pressed
                            load_time_q  <= time_button_i;
                            load_alarm_q <= !time_button_i;
                        end else begin
                            entry_error_q <= 1'b1;
                        end
                    end else if (digit_accept) begin
                        cnt_q <= '0;
                    end else if (one_second_i) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q         <= SHOW_TIME;
                            show_new_time_q <= 1'b0;
                            cnt_q           <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                SHOW_ALARM: begin
                    if (!alarm_button_i) begin
                        state_q      <= SHOW_TIME;
                        show_alarm_q <= 1'b0;
                        cnt_q        <= '0;
                    end else if (one_second_i) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q      <= SHOW_TIME;
                            show_alarm_q <= 1'b0;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q         <= SHOW_TIME;
                    cnt_q           <= '0;
                    show_alarm_q    <= 1'b0;
                    show_new_time_q <= 1'b0;
                end
            endcase
        end
    end

    assign load_alarm_o    = load_alarm_q;
    assign load_time_o     = load_time_q;
    assign entry_error_o   = entry_error_q;
    assign show_alarm_o    = show_alarm_q;
    assign show_new_time_o = show_new_time_q;

endmodule

// File: doc/alarm_key_controller.md
# alarm_key_controller

Keypad-entry controller for the alarm clock: accepts BCD digits from the keypad, assembles them into a 4-digit HH:MM value, and on alarm_button/time_button issues one-cycle load strobes to the alarm register and the time counter. It also drives the display-select controls and abandons an unfinished entry after a period of inactivity. It sits between the keypad decoder and the alarm register and time counter inside alarm_clock_top.

## Interface
- TIMEOUT_S, 10, number of one_second ticks without activity before an entry or alarm display is abandoned
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- one_second  in  1  one-cycle tick from the time base; runs faster when fastwatch is set upstream
- key  in  4  keypad code; only 0–9 are valid digits
- key_valid  in  1  one-cycle strobe qualifying key
- alarm_button  in  1  level, already synchronized
- time_button  in  1  level, already synchronized
- new_time  out  16  entered value {H1,H0,M1,M0}, BCD
- load_alarm  out  1  one-cycle strobe: alarm register captures new_time
- load_time  out  1  one-cycle strobe: time counter captures new_time
- show_alarm  out  1  display selects the stored alarm time
- show_new_time  out  1  display selects new_time
- entry_error  out  1  one-cycle strobe: load rejected (see Configuration)

## Operation
- States: SHOW_TIME (reset state), KEY_ENTRY, SHOW_ALARM.
- SHOW_TIME
  - A valid digit (key_valid=1, key≤9) shifts in and moves the FSM to KEY_ENTRY.
  - alarm_button=1 moves the FSM to SHOW_ALARM.
  - time_button=1 is ignored.
- KEY_ENTRY
  - Each valid digit shifts in: new_time <= {new_time[11:0], key}. After the 4th digit the oldest digit drops off the top.
  - key_valid with key>9 is ignored; the digit is not shifted and the timeout is not restarted.
  - time_button=1 produces load_time and returns the FSM to SHOW_TIME.
  - alarm_button=1 produces load_alarm and returns the FSM to SHOW_TIME.
  - If both buttons are high in the same cycle, time_button wins.
  - If a button and key_valid arrive in the same cycle, the button wins and the digit is discarded.
- SHOW_ALARM
  - The FSM holds while alarm_button=1 and returns to SHOW_TIME on release.
  - Digits are ignored.
- Timeout counter
  - Clears on every state change and on every accepted digit.
  - Increments on one_second while in KEY_ENTRY or SHOW_ALARM.
  - Reaching TIMEOUT_S forces the FSM to SHOW_TIME with no load strobe.
- Display outputs: show_new_time=1 exactly while in KEY_ENTRY; show_alarm=1 exactly while in SHOW_ALARM.
- new_time clears to 0 on every entry into SHOW_TIME, but only after the load strobe cycle so the value is still valid during the strobe.
- Holding a button does not retrigger a load: a new load requires a fresh entry through KEY_ENTRY.

## Timing
- All outputs are registered. Reset value of every output is 0, and the FSM and counter reset to SHOW_TIME/0.
- A digit sampled at edge N appears on new_time after edge N. show_new_time rises at the same edge.
- A button sampled at edge N in KEY_ENTRY:
  - the load strobe is high for the cycle following edge N;
  - new_time holds the entered value during that cycle;
  - new_time clears at edge N+1.
- Timeout exit occurs at the edge that samples the TIMEOUT_S-th tick.
- Reset asserted mid-entry discards the buffer and any pending strobe at that same edge.

## Configuration
- ALARM_KEY_RANGE_CHECK_EN defined:
  - a load is issued only if every digit is ≤9, {H1,H0}≤23 and {M1,M0}≤59;
  - otherwise no load strobe is issued, entry_error pulses for one cycle in place of the strobe, and the FSM returns to SHOW_TIME.
- Not defined: new_time is loaded unchecked and entry_error is tied to 0.

## Structure
- Shared package alarm_clock_pkg holds:
  - the state enum (SHOW_TIME, KEY_ENTRY, SHOW_ALARM);
  - the TIMEOUT_S default;
  - the BCD digit-width constant;
  - the HH:MM range-check function, reused by the time counter.
- One sub-module, alarm_key_shift_reg: the 4-digit BCD shift buffer with shift enable and synchronous clear.

## Test plan
- Keys 2,3,5,9 then time_button → load_time single pulse with new_time=16'h2359; show_new_time high during entry; new_time=0 the cycle after.
- Keys 0,6,3,0 then alarm_button → load_alarm pulse with new_time=16'h0630; load_time stays 0.
- Key 1, then 10 one_second ticks with no activity → return to SHOW_TIME, no strobes, new_time=0; key 4'hA during entry changes nothing.
- Keys 1,2,3,4,5 → new_time=16'h2345; both buttons in the same cycle → load_time only.
- With ALARM_KEY_RANGE_CHECK_EN: keys 2,4,0,0 + time_button → entry_error pulse, no load_time. Keys 1,2,6,0 + time_button → entry_error pulse, no load_time.
- alarm_button held from SHOW_TIME → show_alarm=1 until release. Reset asserted mid-entry → all outputs 0 at the next edge.
